// File: rtl/data_mem_io_pkg.sv
// Memory-map constants and region decode shared by the data-side memory/IO block.
package mem_map_pkg;

  localparam logic [11:0] RAM_BASE = 12'h000;
  localparam logic [11:0] IO_BASE  = 12'h400;

  localparam logic [2:0] IDX_LED    = 3'd0;
  localparam logic [2:0] IDX_SW     = 3'd1;
  localparam logic [2:0] IDX_TCOUNT = 3'd2;
  localparam logic [2:0] IDX_TCMP   = 3'd3;
  localparam logic [2:0] IDX_TCTRL  = 3'd4;

  localparam int unsigned TCTRL_EN     = 0;
  localparam int unsigned TCTRL_IRQ_EN = 1;
  localparam int unsigned TCTRL_FLAG   = 2;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_IO,
    REG_NONE
  } region_e;

  // Takes addr[31:10]; only the low 4 KiB window is mapped.
  function automatic region_e decode_region(input logic [21:0] hi);
    if (hi[21:2] != '0)                return REG_NONE;
    if (hi[1:0] == RAM_BASE[11:10])    return REG_RAM;
    if (hi[1:0] == IO_BASE[11:10])     return REG_IO;
    return REG_NONE;
  endfunction

endpackage

// File: rtl/data_mem_io_if.sv
// Core data-port bus: store strobe, address, store data and combinational load data.
interface data_mem_io_if;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport master (output mem_write, addr, write_data, input read_data);
  modport slave  (input mem_write, addr, write_data, output read_data);
endinterface

// File: rtl/data_mem_io_timer.sv
// 32-bit free-running timer with compare-match flag and interrupt enable.
module io_timer
  import mem_map_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic        cmp_we,
  input  logic        ctrl_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] cmp,
  output logic [2:0]  ctrl,
  output logic        timer_irq
);

  logic en, irq_en, match_flag;
  logic match;

  // Match uses pre-edge en/count, so a same-cycle TCOUNT write still sets the flag.
  assign match = en && (count == cmp);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count      <= '0;
      cmp        <= '1;
      en         <= 1'b0;
      irq_en     <= 1'b0;
      match_flag <= 1'b0;
    end else begin
      if (count_we)  count <= wdata;
      else if (en)   count <= count + 32'd1;

      if (cmp_we) cmp <= wdata;

      if (ctrl_we) begin
        en     <= wdata[TCTRL_EN];
        irq_en <= wdata[TCTRL_IRQ_EN];
      end

      if (match)                             match_flag <= 1'b1;
      else if (ctrl_we && wdata[TCTRL_FLAG]) match_flag <= 1'b0;
    end
  end

  always_comb begin
    ctrl               = '0;
    ctrl[TCTRL_EN]     = en;
    ctrl[TCTRL_IRQ_EN] = irq_en;
    ctrl[TCTRL_FLAG]   = match_flag;
  end

  assign timer_irq = match_flag & irq_en;

endmodule

// File: rtl/data_mem_io.sv
// Data RAM plus memory-mapped LED, switch and timer registers behind the core's data port.
module data_mem_io
  import mem_map_pkg::*;
#(
  parameter int unsigned RAM_WORDS = 256,
  parameter int unsigned NUM_LEDS  = 8,
  parameter int unsigned NUM_SW    = 8
) (
  input  logic                clk,
  input  logic                reset,
  data_mem_io_if.slave        bus,
  input  logic [NUM_SW-1:0]   sw,
  output logic [NUM_LEDS-1:0] leds,
  output logic                timer_irq
);

  localparam int unsigned AW = $clog2(RAM_WORDS);

  region_e       region;
  logic [2:0]    io_idx;
  logic [AW-1:0] ram_idx;
  logic          ram_we, io_we;
  logic          unused_addr;

  assign region      = decode_region(bus.addr[31:10]);
  assign io_idx      = bus.addr[4:2];
  assign ram_idx     = bus.addr[AW+1:2];
  assign ram_we      = bus.mem_write && (region == REG_RAM);
  assign io_we       = bus.mem_write && (region == REG_IO);
  assign unused_addr = ^bus.addr[1:0];

  logic [31:0] ram [RAM_WORDS];

  // RAM deliberately has no reset.
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_idx] <= bus.write_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          leds <= '0;
    else if (io_we && io_idx == IDX_LED) leds <= bus.write_data[NUM_LEDS-1:0];
  end

  logic [NUM_SW-1:0] sw_meta, sw_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
    end
  end

  logic [31:0] t_count, t_cmp;
  logic [2:0]  t_ctrl;

  io_timer u_timer (
    .clk       (clk),
    .reset     (reset),
    .count_we  (io_we && io_idx == IDX_TCOUNT),
    .cmp_we    (io_we && io_idx == IDX_TCMP),
    .ctrl_we   (io_we && io_idx == IDX_TCTRL),
    .wdata     (bus.write_data),
    .count     (t_count),
    .cmp       (t_cmp),
    .ctrl      (t_ctrl),
    .timer_irq (timer_irq)
  );

  always_comb begin
    bus.read_data = '0;
    case (region)
      REG_RAM: bus.read_data = ram[ram_idx];
      REG_IO: begin
        case (io_idx)
          IDX_LED:    bus.read_data = 32'(leds);
          IDX_SW:     bus.read_data = 32'(sw_sync);
          IDX_TCOUNT: bus.read_data = t_count;
          IDX_TCMP:   bus.read_data = t_cmp;
          IDX_TCTRL:  bus.read_data = 32'(t_ctrl);
          default:    bus.read_data = '0;
        endcase
      end
      default: bus.read_data = '0;
    endcase
  end

endmodule

// File: tb/tb_data_mem_io.sv
// Directed bench for data_mem_io: vector table for decode/RAM/IO, hand sequences for timer and sync.
module tb_data_mem_io;

  logic       clk    = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst_n  = 1'b1;
  logic [7:0] sw;
  logic [7:0] leds;
  logic       timer_irq;

  int errors = 0;
  int checks = 0;

  data_mem_io_if bus ();

  data_mem_io #(.RAM_WORDS(256), .NUM_LEDS(8), .NUM_SW(8)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .bus       (bus),
    .sw        (sw),
    .leds      (leds),
    .timer_irq (timer_irq)
  );

  always #5 clk = clk_en ? ~clk : clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.mem_write  = 1'b1;
    bus.addr       = a;
    bus.write_data = d;
    @(posedge clk);
    #1;
    bus.mem_write  = 1'b0;
  endtask

  task automatic load_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    bus.addr = a;
    #1;
    check(name, bus.read_data, exp);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 32'h004,  32'hDEADBEEF, 32'h004,  32'hDEADBEEF, "ram_word1"};
    vecs[1]  = '{1'b0, 32'h0,    32'h0,        32'h1404, 32'h00000000, "unmapped_hi_read"};
    vecs[2]  = '{1'b1, 32'h000,  32'h0BADF00D, 32'h000,  32'h0BADF00D, "ram_word0"};
    vecs[3]  = '{1'b1, 32'h3F8,  32'hCAFEF00D, 32'h3F8,  32'hCAFEF00D, "ram_3f8"};
    vecs[4]  = '{1'b1, 32'h3FC,  32'h12345678, 32'h3FC,  32'h12345678, "ram_top"};
    vecs[5]  = '{1'b0, 32'h0,    32'h0,        32'h3F8,  32'hCAFEF00D, "ram_neighbor"};
    vecs[6]  = '{1'b1, 32'h1004, 32'h11111111, 32'h004,  32'hDEADBEEF, "unmapped_hi_write"};
    vecs[7]  = '{1'b1, 32'h800,  32'h22222222, 32'h000,  32'h0BADF00D, "region2_write"};
    vecs[8]  = '{1'b0, 32'h0,    32'h0,        32'h800,  32'h00000000, "region2_read"};
    vecs[9]  = '{1'b1, 32'hC04,  32'h33333333, 32'hC04,  32'h00000000, "region3"};
    vecs[10] = '{1'b1, 32'h400,  32'h000001FF, 32'h400,  32'h000000FF, "led_rw"};
    vecs[11] = '{1'b1, 32'h414,  32'hFFFFFFFF, 32'h414,  32'h00000000, "io_reserved_414"};
    vecs[12] = '{1'b1, 32'h41C,  32'hFFFFFFFF, 32'h41C,  32'h00000000, "io_reserved_41c"};
    vecs[13] = '{1'b1, 32'h404,  32'h000000FF, 32'h404,  32'h00000000, "sw_read_only"};
    vecs[14] = '{1'b1, 32'h40C,  32'h00000010, 32'h40C,  32'h00000010, "tcmp_rw"};
    vecs[15] = '{1'b1, 32'h410,  32'hFFFFFFF8, 32'h410,  32'h00000000, "tctrl_rw"};
    vecs[16] = '{1'b1, 32'h007,  32'h5A5A5A5A, 32'h004,  32'h5A5A5A5A, "ram_low_bits_ignored"};

    bus.mem_write  = 1'b0;
    bus.addr       = '0;
    bus.write_data = '0;
    sw             = '0;

    // Reset with the clock stopped.
    #2 rst_n = 1'b0;
    #1;
    check("reset_leds", 32'(leds), 32'h0);
    check("reset_irq", 32'(timer_irq), 32'h0);
    load_check("reset_tcmp", 32'h40C, 32'hFFFFFFFF);
    load_check("reset_tcount", 32'h408, 32'h0);
    load_check("reset_tctrl", 32'h410, 32'h0);
    #2 rst_n = 1'b1;
    #2 clk_en = 1'b1;
    tick();

    for (int i = 0; i < 17; i++) begin
      if (vecs[i].we) store(vecs[i].waddr, vecs[i].wdata);
      load_check(vecs[i].name, vecs[i].raddr, vecs[i].exp);
    end
    check("led_port", 32'(leds), 32'h000000FF);

    // Switch synchronizer: visible on the second edge after the change.
    sw = 8'hA5;
    load_check("sw_edge0", 32'h404, 32'h0);
    tick();
    load_check("sw_edge1", 32'h404, 32'h0);
    tick();
    load_check("sw_edge2", 32'h404, 32'h000000A5);

    // Timer wrap and match.
    store(32'h408, 32'hFFFFFFFE);
    store(32'h40C, 32'h00000001);
    store(32'h410, 32'h00000003);
    load_check("tmr_loaded", 32'h408, 32'hFFFFFFFE);
    load_check("tmr_ctrl_on", 32'h410, 32'h3);
    tick();
    tick();
    load_check("tmr_wrap", 32'h408, 32'h0);
    check("tmr_irq_pre", 32'(timer_irq), 32'h0);
    tick();
    load_check("tmr_at_cmp", 32'h408, 32'h1);
    load_check("tmr_flag_pre", 32'h410, 32'h3);
    check("tmr_irq_not_yet", 32'(timer_irq), 32'h0);
    tick();
    load_check("tmr_flag_set", 32'h410, 32'h7);
    check("tmr_irq_set", 32'(timer_irq), 32'h1);
    load_check("tmr_after_match", 32'h408, 32'h2);
    store(32'h410, 32'h00000007);
    load_check("tmr_flag_clear", 32'h410, 32'h3);
    check("tmr_irq_clear", 32'(timer_irq), 32'h0);
    load_check("tmr_count3", 32'h408, 32'h3);

    // TCOUNT write while enabled loads without increment.
    store(32'h408, 32'h0);
    load_check("tmr_load_no_inc", 32'h408, 32'h0);
    tick();
    // Clear request in the match cycle: set wins.
    store(32'h410, 32'h00000007);
    load_check("collide_set_wins", 32'h410, 32'h7);
    check("collide_irq", 32'(timer_irq), 32'h1);

    // Flag sets even when TCOUNT is written in the match cycle.
    store(32'h410, 32'h00000007);
    load_check("collide_clear2", 32'h410, 32'h3);
    store(32'h408, 32'h1);
    store(32'h408, 32'h100);
    load_check("tcount_wr_match_cnt", 32'h408, 32'h100);
    load_check("tcount_wr_match_flag", 32'h410, 32'h7);

    // Disabling: pre-edge en still counts this edge, then counting stops.
    store(32'h410, 32'h00000004);
    load_check("disable_last_inc", 32'h408, 32'h101);
    load_check("disable_ctrl", 32'h410, 32'h0);
    tick();
    load_check("disabled_hold", 32'h408, 32'h101);

    // Asynchronous reset with the clock running; RAM is kept.
    rst_n = 1'b0;
    #1;
    check("rst2_leds", 32'(leds), 32'h0);
    load_check("rst2_tcount", 32'h408, 32'h0);
    load_check("rst2_tcmp", 32'h40C, 32'hFFFFFFFF);
    load_check("rst2_sw", 32'h404, 32'h0);
    load_check("rst2_ram_kept", 32'h004, 32'h5A5A5A5A);
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_io.md
# data_mem_io

Data-side memory and memory-mapped I/O block sitting directly downstream of the single-cycle ARM core.
- Consumes the core's data-port outputs `MemWrite`, `ALUResult` (used as the address) and `WriteData`; returns `ReadData` in the same cycle.
- Address decode selects a word-addressed data RAM or a small I/O register file: LEDs, synchronized switches and a 32-bit timer with compare-match interrupt flag.

## Interface
Parameters:
- `RAM_WORDS`, 256 — data RAM depth in 32-bit words (power of two, ≤256).
- `NUM_LEDS`, 8 — LED output width (≤32).
- `NUM_SW`, 8 — switch input width (≤32).

Ports:
- `clk` in 1 — single clock; all state updates on the rising edge.
- `reset` in 1 — asynchronous, active-low reset.
- `mem_write` in 1 — store strobe from the core; write occurs at the rising edge while high.
- `addr` in 32 — byte address from the core's ALU result; `addr[1:0]` ignored (word accesses only).
- `write_data` in 32 — store data.
- `read_data` out 32 — load data, combinational from `addr` and current state.
- `sw` in NUM_SW — asynchronous board switches.
- `leds` out NUM_LEDS — registered LED drive.
- `timer_irq` out 1 — `match_flag & irq_en`.

## Operation
Memory map. Mapped only when `addr[31:12]==0`; everything else is unmapped.
- `addr[11:10]==00`: RAM, word index `addr[9:2]` modulo `RAM_WORDS`.
- `addr[11:10]==01`: I/O, register index `addr[4:2]`:
  - 0x400 LED (RW): low NUM_LEDS bits; reads zero-extended.
  - 0x404 SW (RO): synchronized switches, zero-extended; writes ignored.
  - 0x408 TCOUNT (RW): timer count.
  - 0x40C TCMP (RW): compare value.
  - 0x410 TCTRL (RW): bit0 `en`, bit1 `irq_en`, bit2 `match_flag`. Writing 1 to bit2 clears the flag; writing 0 to bit2 has no effect. Other bits read 0.
  - 0x414–0x41C: read 0, writes ignored.
- Unmapped (including `addr[11:10]` = 10 or 11): read 0x00000000, writes ignored.

RAM:
- Asynchronous read, synchronous write.
- Not reset; contents are undefined until first written.

Timer, evaluated at each rising edge:
- Count: if a TCOUNT write is present, `count <= write_data`; else if `en`, `count <= count+1` (wraps 0xFFFFFFFF→0).
- Flag set: if `en` and `count==TCMP` (pre-edge values), `match_flag <= 1`. This applies even when TCOUNT is being written in the same cycle.
- Clear vs. set: a TCTRL write with bit2=1 clears the flag; a set in the same cycle wins.
- Enable: a TCTRL write updates `en` and `irq_en` at that edge. The pre-edge `en` governs counting and flag set in that cycle.

Switch input: two-flop synchronizer per bit.

## Timing
- Loads: `read_data` is valid combinationally in the same cycle `addr` is stable; zero added latency.
- Stores: a store at edge N is visible on `read_data` after edge N. Back-to-back store then load to the same address returns the new data.
- Switches: an `sw` change appears in SW reads 2 edges after it is sampled.
- Timer flag: the flag sets at the edge where `count==TCMP` is observed. `timer_irq` rises immediately after that edge if `irq_en`=1.
- Reset values (asserted asynchronously, independent of `clk`):
  - `leds`=0, synchronizer=0.
  - count=0, TCMP=0xFFFFFFFF, `en`=0, `irq_en`=0, `match_flag`=0, `timer_irq`=0.
  - RAM untouched.
- Reset mid-store: the store is lost for I/O registers; RAM may or may not take the write.

## Structure
- Package `mem_map_pkg`:
  - Region base constants (RAM_BASE 0x000, IO_BASE 0x400).
  - Register index localparams (LED=0, SW=1, TCOUNT=2, TCMP=3, TCTRL=4).
  - TCTRL bit positions.
  - Region-decode enum (`REG_RAM`, `REG_IO`, `REG_NONE`).
- Sub-module `io_timer`: count/compare/ctrl registers, flag set/clear priority, `timer_irq`. Its inputs are the write strobes and write data.
- Top level holds: address decode, RAM array, LED register, switch synchronizer and the read mux.

## Test plan
- **Reset:** assert reset low with `clk` stopped. Expect `leds`=0 and `timer_irq`=0, and TCMP reads 0xFFFFFFFF.
- **RAM:** store 0xDEADBEEF to 0x004, then load 0x004 next cycle → 0xDEADBEEF. Load 0x404+0x1000 (unmapped) → 0.
- **RAM wrap:** with RAM_WORDS=256, store 0x12345678 to 0x3FC, then load 0x3FC → 0x12345678. Load 0x3F8 is unaffected.
- **Switches / LEDs:** drive `sw`=0xA5. SW read returns 0xA5 on the 2nd edge after the change, not before. Store 0x1FF to 0x400 → `leds`=0xFF, and a read returns 0xFF.
- **Timer match:** TCOUNT=0xFFFFFFFE, TCMP=0x1, TCTRL=0x3.
  - Count wraps to 0 after two edges.
  - Flag and `timer_irq` rise after the edge where count==1.
  - Write TCTRL=0x7 → flag clears.
- **Clear/set collision:** write TCTRL=0x7 in exactly the match cycle → flag stays 1. Writing TCOUNT during an enabled cycle loads the written value with no increment.
